// File: rtl/compress_ctrl_pkg.sv
// Shared constants and types for the compress core AXI4-Lite control block.
// Register offsets are word indices taken from address bits [3:2].
package compress_ctrl_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_LEN    = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_RESULT = 2'd3;

  localparam int CTRL_START_BIT     = 0;
  localparam int CTRL_IRQ_EN_BIT    = 1;
  localparam int STAT_BUSY_BIT      = 0;
  localparam int STAT_DONE_BIT      = 1;
  localparam int STAT_START_IGN_BIT = 2;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    BUSY = 2'd2
  } job_state_t;

  // Merge write data into an existing word, one byte lane per strobe bit.
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/compress_job_seq.sv
// Job sequencer: issues one job to the compress core and tracks
// the BUSY/DONE/START_IGN status and the RESULT byte count.
module compress_job_seq
  import compress_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic        done_w1c_i,
  input  logic        start_ign_w1c_i,
  input  logic [31:0] len_i,
  input  logic        job_ready_i,
  input  logic        done_valid_i,
  input  logic [31:0] done_bytes_i,
  output logic        job_valid_o,
  output logic [31:0] job_len_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        start_ign_o,
  output logic [31:0] result_o
);

  job_state_t  state_q, state_d;
  logic [31:0] job_len_q, job_len_d;
  logic [31:0] result_q, result_d;
  logic        done_q, done_d;
  logic        start_ign_q, start_ign_d;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    job_len_d   = job_len_q;
    result_d    = result_q;
    done_d      = done_q & ~done_w1c_i;
    start_ign_d = start_ign_q & ~start_ign_w1c_i;
    // Hardware sets below override any same-cycle W1C clear above.
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (len_i != 32'd0) begin
            state_d   = REQ;
            job_len_d = len_i;
          end else begin
            done_d   = 1'b1;
            result_d = 32'd0;
          end
        end
      end
      REQ: begin
        if (start_i)     start_ign_d = 1'b1;
        if (job_ready_i) state_d     = BUSY;
      end
      BUSY: begin
        if (start_i) start_ign_d = 1'b1;
        if (done_valid_i) begin
          state_d  = IDLE;
          result_d = done_bytes_i;
          done_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      job_len_q   <= '0;
      result_q    <= '0;
      done_q      <= 1'b0;
      start_ign_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      job_len_q   <= job_len_d;
      result_q    <= result_d;
      done_q      <= done_d;
      start_ign_q <= start_ign_d;
    end
  end

  // Decoded straight from state so an asynchronous reset drops the request at once.
  assign job_valid_o = (state_q == REQ);
  assign job_len_o   = job_len_q;
  assign busy_o      = (state_q != IDLE);
  assign done_o      = done_q;
  assign start_ign_o = start_ign_q;
  assign result_o    = result_q;

endmodule

// File: rtl/compress_core_ctrl_axil.sv
// AXI4-Lite slave front end for the compress core: CTRL/LEN/STATUS/RESULT
// registers, independent AW/W holding slots and a registered level interrupt.
module compress_core_ctrl_axil
  import compress_ctrl_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            s00_axi_aclk,
  input  logic                            s00_axi_aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]                      s00_axi_awprot,
  input  logic                            s00_axi_awvalid,
  output logic                            s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                            s00_axi_wvalid,
  output logic                            s00_axi_wready,
  output logic [1:0]                      s00_axi_bresp,
  output logic                            s00_axi_bvalid,
  input  logic                            s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]                      s00_axi_arprot,
  input  logic                            s00_axi_arvalid,
  output logic                            s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                      s00_axi_rresp,
  output logic                            s00_axi_rvalid,
  input  logic                            s00_axi_rready,
  output logic                            job_valid,
  input  logic                            job_ready,
  output logic [31:0]                     job_len,
  input  logic                            done_valid,
  input  logic [31:0]                     done_bytes,
  output logic                            irq
);

  logic        aw_held_q, w_held_q, bvalid_q, rvalid_q, irq_en_q, irq_q;
  logic [1:0]  aw_idx_q;
  logic [31:0] w_data_q, len_q, rdata_q, rd_mux;
  logic [3:0]  w_strb_q;
  logic        commit, wr_ctrl, wr_len, wr_status, ar_hs;
  logic        busy, done, start_ign;
  logic [31:0] result;
  logic        unused_ok;

  assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot,
                       s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

  assign commit    = aw_held_q & w_held_q & ~bvalid_q;
  assign wr_ctrl   = commit & (aw_idx_q == REG_CTRL);
  assign wr_len    = commit & (aw_idx_q == REG_LEN);
  assign wr_status = commit & (aw_idx_q == REG_STATUS) & w_strb_q[0];
  assign ar_hs     = s00_axi_arvalid & ~rvalid_q;

  always_comb begin
    rd_mux = '0;
    case (s00_axi_araddr[3:2])
      REG_CTRL:   rd_mux[CTRL_IRQ_EN_BIT] = irq_en_q;
      REG_LEN:    rd_mux = len_q;
      REG_STATUS: begin
        rd_mux[STAT_BUSY_BIT]      = busy;
        rd_mux[STAT_DONE_BIT]      = done;
        rd_mux[STAT_START_IGN_BIT] = start_ign;
      end
      default:    rd_mux = result;
    endcase
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      aw_held_q <= 1'b0;
      aw_idx_q  <= '0;
      w_held_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      irq_en_q  <= 1'b0;
      len_q     <= '0;
      irq_q     <= 1'b0;
    end else begin
      if (s00_axi_awvalid && !aw_held_q) begin
        aw_held_q <= 1'b1;
        aw_idx_q  <= s00_axi_awaddr[3:2];
      end else if (commit) begin
        aw_held_q <= 1'b0;
      end
      if (s00_axi_wvalid && !w_held_q) begin
        w_held_q <= 1'b1;
        w_data_q <= s00_axi_wdata;
        w_strb_q <= s00_axi_wstrb;
      end else if (commit) begin
        w_held_q <= 1'b0;
      end
      if (commit)              bvalid_q <= 1'b1;
      else if (s00_axi_bready) bvalid_q <= 1'b0;
      if (ar_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_mux;
      end else if (s00_axi_rready) begin
        rvalid_q <= 1'b0;
      end
      if (wr_ctrl && w_strb_q[0]) irq_en_q <= w_data_q[CTRL_IRQ_EN_BIT];
      if (wr_len) len_q <= apply_wstrb(len_q, w_data_q, w_strb_q);
      irq_q <= irq_en_q & done;
    end
  end

  compress_job_seq u_job_seq (
    .clk             (s00_axi_aclk),
    .rst_n           (s00_axi_aresetn),
    .start_i         (wr_ctrl & w_strb_q[0] & w_data_q[CTRL_START_BIT]),
    .done_w1c_i      (wr_status & w_data_q[STAT_DONE_BIT]),
    .start_ign_w1c_i (wr_status & w_data_q[STAT_START_IGN_BIT]),
    .len_i           (len_q),
    .job_ready_i     (job_ready),
    .done_valid_i    (done_valid),
    .done_bytes_i    (done_bytes),
    .job_valid_o     (job_valid),
    .job_len_o       (job_len),
    .busy_o          (busy),
    .done_o          (done),
    .start_ign_o     (start_ign),
    .result_o        (result)
  );

  assign s00_axi_awready = ~aw_held_q;
  assign s00_axi_wready  = ~w_held_q;
  assign s00_axi_bresp   = AXI_RESP_OKAY;
  assign s00_axi_bvalid  = bvalid_q;
  assign s00_axi_arready = ~rvalid_q;
  assign s00_axi_rdata   = rdata_q;
  assign s00_axi_rresp   = AXI_RESP_OKAY;
  assign s00_axi_rvalid  = rvalid_q;
  assign irq             = irq_q;

endmodule

// File: tb/tb_compress_core_ctrl_axil.sv
// Directed bench for compress_core_ctrl_axil: register access, job flow,
// write-channel ordering/backpressure and asynchronous reset mid-job.
module tb_compress_core_ctrl_axil;

  logic        clk = 1'b0;
  logic        aresetn;
  logic [3:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        job_valid, job_ready, done_valid, irq;
  logic [31:0] job_len, done_bytes;

  int tests = 0;
  int fails = 0;
  int lat;

  always #5 clk = ~clk;

  compress_core_ctrl_axil dut (
    .s00_axi_aclk    (clk),
    .s00_axi_aresetn (aresetn),
    .s00_axi_awaddr  (awaddr),
    .s00_axi_awprot  (awprot),
    .s00_axi_awvalid (awvalid),
    .s00_axi_awready (awready),
    .s00_axi_wdata   (wdata),
    .s00_axi_wstrb   (wstrb),
    .s00_axi_wvalid  (wvalid),
    .s00_axi_wready  (wready),
    .s00_axi_bresp   (bresp),
    .s00_axi_bvalid  (bvalid),
    .s00_axi_bready  (bready),
    .s00_axi_araddr  (araddr),
    .s00_axi_arprot  (arprot),
    .s00_axi_arvalid (arvalid),
    .s00_axi_arready (arready),
    .s00_axi_rdata   (rdata),
    .s00_axi_rresp   (rresp),
    .s00_axi_rvalid  (rvalid),
    .s00_axi_rready  (rready),
    .job_valid       (job_valid),
    .job_ready       (job_ready),
    .job_len         (job_len),
    .done_valid      (done_valid),
    .done_bytes      (done_bytes),
    .irq             (irq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Presents AW and W together, then waits for and completes the B handshake.
  // lat = number of sampled cycles with bvalid low after the last address/data handshake.
  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output int latency);
    logic aw_hs, w_hs, got_b;
    @(negedge clk);
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    for (int i = 0; i < 20 && (awvalid || wvalid); i++) begin
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      @(posedge clk); #1;
      if (aw_hs) awvalid = 1'b0;
      if (w_hs)  wvalid  = 1'b0;
      if (awvalid || wvalid) @(negedge clk);
    end
    check("wr_accept", {31'b0, !(awvalid || wvalid)}, 32'd1);
    awvalid = 1'b0; wvalid = 1'b0;
    got_b = 1'b0; latency = 0;
    for (int i = 0; i < 20 && !got_b; i++) begin
      @(negedge clk);
      if (bvalid) got_b = 1'b1;
      else latency++;
    end
    check("wr_bvalid", {31'b0, got_b}, 32'd1);
    check("wr_bresp", {30'b0, bresp}, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic axi_read_check(input string tag, input logic [3:0] addr, input logic [31:0] exp);
    logic got_ar, got_r;
    logic [31:0] d;
    @(negedge clk);
    araddr = addr; arvalid = 1'b1; rready = 1'b1;
    got_ar = 1'b0;
    for (int i = 0; i < 20 && !got_ar; i++) begin
      if (arready) got_ar = 1'b1;
      else @(negedge clk);
    end
    @(posedge clk); #1;
    arvalid = 1'b0;
    got_r = 1'b0; d = '0;
    for (int i = 0; i < 20 && !got_r; i++) begin
      @(negedge clk);
      if (rvalid) begin
        got_r = 1'b1;
        d = rdata;
      end
    end
    check({tag, "_rvalid"}, {31'b0, got_ar & got_r}, 32'd1);
    check(tag, d, exp);
    @(posedge clk); #1;
  endtask

  initial begin
    aresetn = 1'b0;
    awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
    awvalid = 1'b0; wvalid = 1'b0; wdata = '0; wstrb = '0; bready = 1'b1;
    arvalid = 1'b0; rready = 1'b1;
    job_ready = 1'b0; done_valid = 1'b0; done_bytes = '0;
    repeat (3) @(negedge clk);
    check("rst_job_valid", {31'b0, job_valid}, 32'd0);
    check("rst_bvalid", {31'b0, bvalid}, 32'd0);
    check("rst_rvalid", {31'b0, rvalid}, 32'd0);
    check("rst_irq", {31'b0, irq}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    aresetn = 1'b1;

    // Basic register access; AW and W in the same cycle.
    axi_write(4'h4, 32'h0000_1000, 4'hF, lat);
    check("wr_latency", lat, 32'd1);
    axi_read_check("len_rd", 4'h4, 32'h0000_1000);
    axi_read_check("status_rst", 4'h8, 32'h0);

    // Job issue with core backpressure.
    axi_write(4'h4, 32'h0000_0100, 4'hF, lat);
    axi_write(4'h0, 32'h0000_0003, 4'hF, lat);
    check("job_valid_up", {31'b0, job_valid}, 32'd1);
    check("job_len", job_len, 32'h0000_0100);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("job_valid_hold", {31'b0, job_valid}, 32'd1);
    end
    axi_read_check("status_req", 4'h8, 32'h1);
    axi_read_check("ctrl_rd", 4'h0, 32'h2);
    @(negedge clk); job_ready = 1'b1;
    @(posedge clk); #1; job_ready = 1'b0;
    @(negedge clk);
    check("job_valid_drop", {31'b0, job_valid}, 32'd0);

    // START and LEN writes while busy.
    axi_write(4'h4, 32'h0000_0999, 4'hF, lat);
    axi_write(4'h0, 32'h0000_0003, 4'hF, lat);
    @(negedge clk);
    check("no_second_job", {31'b0, job_valid}, 32'd0);
    check("job_len_stable", job_len, 32'h0000_0100);
    axi_read_check("status_ign", 4'h8, 32'h5);
    axi_write(4'h8, 32'h0000_0004, 4'hF, lat);
    axi_read_check("status_ign_clr", 4'h8, 32'h1);

    // Completion and 1-cycle irq lag.
    @(negedge clk); done_valid = 1'b1; done_bytes = 32'h0000_0040;
    @(posedge clk); #1; done_valid = 1'b0; done_bytes = 32'h0;
    @(negedge clk);
    check("irq_lag", {31'b0, irq}, 32'd0);
    @(negedge clk);
    check("irq_set", {31'b0, irq}, 32'd1);
    axi_read_check("result", 4'hC, 32'h0000_0040);
    axi_read_check("status_done", 4'h8, 32'h2);

    // done_valid while idle is ignored; RESULT writes are ignored.
    @(negedge clk); done_valid = 1'b1; done_bytes = 32'h0000_0077;
    @(posedge clk); #1; done_valid = 1'b0;
    axi_write(4'hC, 32'hDEAD_BEEF, 4'hF, lat);
    axi_read_check("result_hold", 4'hC, 32'h0000_0040);

    // W1C of DONE, then a zero-length start.
    axi_write(4'h8, 32'h0000_0002, 4'hF, lat);
    axi_read_check("status_w1c", 4'h8, 32'h0);
    check("irq_cleared", {31'b0, irq}, 32'd0);
    axi_write(4'h4, 32'h0, 4'hF, lat);
    axi_write(4'h0, 32'h0000_0001, 4'hF, lat);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("len0_no_job", {31'b0, job_valid}, 32'd0);
    end
    axi_read_check("len0_status", 4'h8, 32'h2);
    axi_read_check("len0_result", 4'hC, 32'h0);

    // W three cycles ahead of AW, with B backpressure.
    @(negedge clk);
    bready = 1'b0; wvalid = 1'b1; wdata = 32'h55; wstrb = 4'hF;
    @(posedge clk); #1; wvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("w_held_wready", {31'b0, wready}, 32'd0);
      check("w_held_no_b", {31'b0, bvalid}, 32'd0);
    end
    @(negedge clk);
    check("aw_ready_alone", {31'b0, awready}, 32'd1);
    awvalid = 1'b1; awaddr = 4'h4;
    @(posedge clk); #1; awvalid = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("b_held", {31'b0, bvalid}, 32'd1);
    end
    bready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("b_released", {31'b0, bvalid}, 32'd0);
    axi_read_check("late_aw_len", 4'h4, 32'h0000_0055);
    axi_write(4'h4, 32'h0000_0066, 4'hF, lat);
    axi_read_check("next_write", 4'h4, 32'h0000_0066);
    axi_write(4'h4, 32'hAABB_CCDD, 4'h2, lat);
    axi_read_check("wstrb_lane1", 4'h4, 32'h0000_CC66);

    // Asynchronous reset with a job in REQ and responses pending.
    axi_write(4'h4, 32'h0000_0010, 4'hF, lat);
    axi_write(4'h0, 32'h0000_0003, 4'hF, lat);
    @(negedge clk);
    rready = 1'b0; arvalid = 1'b1; araddr = 4'hC;
    @(posedge clk); #1; arvalid = 1'b0;
    @(negedge clk);
    bready = 1'b0; awvalid = 1'b1; wvalid = 1'b1; awaddr = 4'h4; wdata = 32'h20; wstrb = 4'hF;
    @(posedge clk); #1; awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk); @(negedge clk);
    check("pre_rst_job_valid", {31'b0, job_valid}, 32'd1);
    check("pre_rst_irq", {31'b0, irq}, 32'd1);
    check("pre_rst_rvalid", {31'b0, rvalid}, 32'd1);
    check("pre_rst_bvalid", {31'b0, bvalid}, 32'd1);
    #2 aresetn = 1'b0;
    #1;
    check("arst_job_valid", {31'b0, job_valid}, 32'd0);
    check("arst_bvalid", {31'b0, bvalid}, 32'd0);
    check("arst_rvalid", {31'b0, rvalid}, 32'd0);
    check("arst_irq", {31'b0, irq}, 32'd0);
    @(negedge clk);
    aresetn = 1'b1; rready = 1'b1; bready = 1'b1;
    axi_read_check("post_rst_ctrl", 4'h0, 32'h0);
    axi_read_check("post_rst_len", 4'h4, 32'h0);
    axi_read_check("post_rst_status", 4'h8, 32'h0);
    axi_read_check("post_rst_result", 4'hC, 32'h0);
    check("post_rst_job_len", job_len, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/compress_core_ctrl_axil.md
Name: compress_core_ctrl_axil

Overview:
- AXI4-Lite slave register block for the compress core.
- Directly downstream of the AXI4-Lite master; decodes register writes and reads.
- Drives one job at a time to the compress core through a valid/ready handshake, then collects the compressed byte count.
- Exposes STATUS/RESULT registers and a level interrupt.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 supported.
- C_S_AXI_ADDR_WIDTH, 4, byte address width; 4 word registers, decode on addr[3:2].

Ports:
- s00_axi_aclk  in  1  single clock.
- s00_axi_aresetn  in  1  reset, asynchronous, active-low.
- s00_axi_awaddr  in  C_S_AXI_ADDR_WIDTH  write address.
- s00_axi_awprot  in  3  ignored.
- s00_axi_awvalid/awready  in/out  1  AW handshake.
- s00_axi_wdata  in  32  write data.
- s00_axi_wstrb  in  4  byte strobes.
- s00_axi_wvalid/wready  in/out  1  W handshake.
- s00_axi_bresp  out  2  always OKAY (2'b00).
- s00_axi_bvalid/bready  out/in  1  B handshake.
- s00_axi_araddr  in  C_S_AXI_ADDR_WIDTH  read address.
- s00_axi_arprot  in  3  ignored.
- s00_axi_arvalid/arready  in/out  1  AR handshake.
- s00_axi_rdata  out  32  read data.
- s00_axi_rresp  out  2  always OKAY.
- s00_axi_rvalid/rready  out/in  1  R handshake.
- job_valid  out  1  job request to core.
- job_ready  in  1  core accepts job.
- job_len  out  32  input length in bytes; stable while job_valid.
- done_valid  in  1  single-cycle completion pulse from core.
- done_bytes  in  32  compressed size, valid with done_valid.
- irq  out  1  level interrupt.

Behaviour:
- Reset: all registers, valid/ready outputs, irq, job_valid and rdata go to 0; FSM enters IDLE.
- Reset mid-job aborts the job: job_valid drops asynchronously.

Register map:
- 0x0 CTRL:
  - bit0 START: write-1 pulse, reads 0.
  - bit1 IRQ_EN: RW.
  - other bits read 0.
- 0x4 LEN: RW 32-bit, per-byte wstrb honoured.
- 0x8 STATUS:
  - bit0 BUSY: RO.
  - bit1 DONE: sticky, W1C.
  - bit2 START_IGN: sticky, W1C.
- 0xC RESULT: RO, last done_bytes. Writes are ignored but still get an OKAY response.

Write channel:
- AW and W are accepted independently; each is latched in a holding register.
- awready=1 while no AW is held; wready=1 while no W is held.
- The register update happens in the cycle both are held and bvalid=0. bvalid is set the next cycle and the holding registers clear.
- AW and W arriving in the same cycle give bvalid 1 cycle later.
- No new AW or W is accepted while bvalid=1 with its slot already full.
- bvalid stays high until bready.

Read channel:
- arready=1 while rvalid=0.
- rdata is registered; rvalid is set 1 cycle after the AR handshake and held until rready.
- Read value is sampled at AR acceptance.

Job FSM (IDLE, REQ, BUSY):
- IDLE to REQ: START written with LEN!=0. job_len is loaded from LEN; job_valid=1 from the next cycle.
- IDLE with LEN==0 and START: no job is issued. Next cycle DONE=1 and RESULT=0; stay IDLE.
- REQ to BUSY: on job_valid&job_ready; job_valid drops the next cycle.
- BUSY to IDLE: on done_valid. RESULT<=done_bytes and DONE<=1 in the same edge.
- BUSY=1 in REQ and BUSY.
- START in REQ/BUSY is ignored and sets START_IGN.
- LEN writes during a job do not alter job_len.
- done_valid in IDLE/REQ is ignored.
- DONE set by hardware and a W1C write in the same cycle: set wins.
- irq = IRQ_EN & DONE, registered, so 1-cycle lag.

Decomposition:
- Package compress_ctrl_pkg:
  - register offsets (REG_CTRL=2'd0 … REG_RESULT=2'd3);
  - CTRL/STATUS bit-position constants;
  - job_state_t enum {IDLE, REQ, BUSY};
  - AXI_RESP_OKAY.
- Sub-module compress_job_seq: the job FSM plus the RESULT/DONE/START_IGN logic. Inputs are the decoded start pulse and W1C bits; outputs are the status fields.
- The AXI-Lite front end stays in the top.

Test Plan:
- Write 0x4=0x00001000 via AW/W same cycle -> bvalid 1 cycle later, bresp=0. Read 0x4 -> 0x00001000. Read 0x8 -> 0x0.
- Write LEN=0x100, then CTRL=0x3 -> job_valid=1 with job_len=0x100. Hold job_ready=0 for 5 cycles -> job_valid stays high and STATUS=0x1. job_ready=1 -> job_valid drops. done_valid with done_bytes=0x40 -> RESULT=0x40, STATUS=0x2, irq=1 the next cycle.
- During BUSY write CTRL=0x1 -> no second job, STATUS=0x5. Write STATUS=0x4 -> START_IGN cleared, STATUS=0x1.
- LEN=0, CTRL=0x1 -> job_valid never asserts, STATUS=0x2, RESULT=0.
- W presented 3 cycles before AW, and bready held low 4 cycles -> single write committed, bvalid held 4 cycles, no further AW/W accepted. Next write succeeds.
- Assert aresetn=0 while in REQ -> job_valid, bvalid, rvalid and irq are 0 immediately. After release, all registers read 0.
